// File: rtl/dfe_stream_ctrl.sv
// -----------------------------------------------------------------------------
// dfe_stream_ctrl
//
// Streams signed 8-bit stimulus samples from the sample memory into the DFE
// filter chain at a fixed divided rate, latches the CIC decimation select for
// the whole run, counts chain outputs, gathers sticky overflow/underflow status
// and declares the run finished once the chain output has been quiet for
// DRAIN_CYCLES clocks.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   start, abort          one-cycle control pulses (abort wins over start)
//   cfg_num_samples       samples to stream, sampled on start
//   cfg_cic_dec_factor    CIC decimation select, sampled on start
//   mem_addr / mem_rdata  sample-memory read port (synchronous, 1-cycle read)
//   chain_in, chain_valid_in, chain_cic_dec_factor   drive side of the chain
//   chain_valid_out, chain_flags                     status side of the chain
//   busy, done            run status (RUN/DRAIN, DONE)
//   err_sticky            per-bit sticky capture of chain_flags
//   out_count             saturating count of chain_valid_out pulses
// -----------------------------------------------------------------------------
module dfe_stream_ctrl #(
  parameter int ADDR_W       = 19,
  parameter int RATE_DIV     = 4,
  parameter int DRAIN_CYCLES = 256,
  parameter int FLAG_W       = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_num_samples,
  input  logic              cfg_cic_dec_factor,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        chain_in,
  output logic              chain_valid_in,
  output logic              chain_cic_dec_factor,
  input  logic              chain_valid_out,
  input  logic [FLAG_W-1:0] chain_flags,
  output logic              busy,
  output logic              done,
  output logic [FLAG_W-1:0] err_sticky,
  output logic [ADDR_W-1:0] out_count
);

  localparam int DIV_W  = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam int IDLE_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(RATE_DIV - 1);
  localparam logic [IDLE_W:0]   IDLE_TGT = (IDLE_W + 1)'(DRAIN_CYCLES - 1);
  localparam logic [ADDR_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   num_reg, num_next;
  logic [ADDR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [DIV_W-1:0]    div_cnt_reg, div_cnt_next;
  logic [IDLE_W-1:0]   idle_cnt_reg, idle_cnt_next;
  logic [IDLE_W:0]     idle_inc;
  // rd_pending: address is on mem_addr this cycle.
  // rdata_valid: memory is presenting that address's data this cycle.
  logic                rd_pending_reg, rd_pending_next;
  logic                rdata_valid_reg, rdata_valid_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [7:0]          chain_in_reg, chain_in_next;
  logic                valid_in_reg, valid_in_next;
  logic                cic_reg, cic_next;
  logic [ADDR_W-1:0]   out_count_reg, out_count_next;
  logic [FLAG_W-1:0]   err_reg, err_next;
  logic                active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      num_reg         <= '0;
      rd_ptr_reg      <= '0;
      div_cnt_reg     <= '0;
      idle_cnt_reg    <= '0;
      rd_pending_reg  <= 1'b0;
      rdata_valid_reg <= 1'b0;
      mem_addr_reg    <= '0;
      chain_in_reg    <= '0;
      valid_in_reg    <= 1'b0;
      cic_reg         <= 1'b0;
      out_count_reg   <= '0;
      err_reg         <= '0;
    end else begin
      state_reg       <= state_next;
      num_reg         <= num_next;
      rd_ptr_reg      <= rd_ptr_next;
      div_cnt_reg     <= div_cnt_next;
      idle_cnt_reg    <= idle_cnt_next;
      rd_pending_reg  <= rd_pending_next;
      rdata_valid_reg <= rdata_valid_next;
      mem_addr_reg    <= mem_addr_next;
      chain_in_reg    <= chain_in_next;
      valid_in_reg    <= valid_in_next;
      cic_reg         <= cic_next;
      out_count_reg   <= out_count_next;
      err_reg         <= err_next;
    end
  end

  assign active   = (state_reg == RUN) || (state_reg == DRAIN);
  assign idle_inc = {1'b0, idle_cnt_reg} + 1'b1;

  always_comb begin
    state_next       = state_reg;
    num_next         = num_reg;
    rd_ptr_next      = rd_ptr_reg;
    div_cnt_next     = div_cnt_reg;
    idle_cnt_next    = idle_cnt_reg;
    rd_pending_next  = 1'b0;
    rdata_valid_next = 1'b0;
    mem_addr_next    = mem_addr_reg;
    chain_in_next    = chain_in_reg;
    valid_in_next    = 1'b0;
    cic_next         = cic_reg;
    out_count_next   = out_count_reg;
    err_next         = err_reg;

    // Status gathering freezes on the abort cycle so the aborted run's
    // totals stay exactly as they were when abort arrived.
    if (active && !abort) begin
      err_next = err_reg | chain_flags;
      if (chain_valid_out && (out_count_reg != CNT_MAX))
        out_count_next = out_count_reg + 1'b1;
    end

    case (state_reg)
      IDLE, DONE: begin
        if (start && !abort) begin
          num_next       = cfg_num_samples;
          cic_next       = cfg_cic_dec_factor;
          rd_ptr_next    = '0;
          div_cnt_next   = '0;
          idle_cnt_next  = '0;
          out_count_next = '0;
          err_next       = '0;
          state_next     = (cfg_num_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          div_cnt_next = (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + 1'b1;
          if ((div_cnt_reg == '0) && (rd_ptr_reg < num_reg)) begin
            mem_addr_next   = rd_ptr_reg;
            rd_ptr_next     = rd_ptr_reg + 1'b1;
            rd_pending_next = 1'b1;
          end
          rdata_valid_next = rd_pending_reg;
          if (rdata_valid_reg) begin
            chain_in_next = mem_rdata;
            valid_in_next = 1'b1;
          end
          if ((rd_ptr_reg == num_reg) && !rd_pending_reg && !rdata_valid_reg) begin
            state_next    = DRAIN;
            idle_cnt_next = '0;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (chain_valid_out) begin
          idle_cnt_next = '0;
        end else begin
          // Leaving on the clock where the count reaches its last value puts
          // done exactly DRAIN_CYCLES clocks after the final output pulse.
          idle_cnt_next = idle_inc[IDLE_W-1:0];
          if (idle_inc >= IDLE_TGT) state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_addr             = mem_addr_reg;
  assign chain_in             = chain_in_reg;
  assign chain_valid_in       = valid_in_reg;
  assign chain_cic_dec_factor = cic_reg;
  assign busy                 = active;
  assign done                 = (state_reg == DONE);
  assign err_sticky           = err_reg;
  assign out_count            = out_count_reg;

endmodule

// File: tb/tb_dfe_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dfe_stream_ctrl
//
// Scoreboard bench for dfe_stream_ctrl. The reference for a run of N samples
// is simply "memory words 0..N-1 in order, each strobed two clocks after its
// address appears, strobes RATE_DIV clocks apart"; out_count and err_sticky
// are tallied from the chain stimulus the bench itself drives.
// -----------------------------------------------------------------------------
module tb_dfe_stream_ctrl;

  localparam int ADDR_W       = 19;
  localparam int RATE_DIV     = 4;
  localparam int DRAIN_CYCLES = 256;
  localparam int FLAG_W       = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] cfg_num_samples = '0;
  logic              cfg_cic_dec_factor = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata = 8'h00;
  logic [7:0]        chain_in;
  logic              chain_valid_in;
  logic              chain_cic_dec_factor;
  logic              chain_valid_out = 1'b0;
  logic [FLAG_W-1:0] chain_flags = '0;
  logic              busy;
  logic              done;
  logic [FLAG_W-1:0] err_sticky;
  logic [ADDR_W-1:0] out_count;

  dfe_stream_ctrl #(
    .ADDR_W(ADDR_W), .RATE_DIV(RATE_DIV),
    .DRAIN_CYCLES(DRAIN_CYCLES), .FLAG_W(FLAG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_num_samples(cfg_num_samples), .cfg_cic_dec_factor(cfg_cic_dec_factor),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .chain_in(chain_in), .chain_valid_in(chain_valid_in),
    .chain_cic_dec_factor(chain_cic_dec_factor),
    .chain_valid_out(chain_valid_out), .chain_flags(chain_flags),
    .busy(busy), .done(done), .err_sticky(err_sticky), .out_count(out_count)
  );

  always #5 clk = ~clk;

  // Sample memory: synchronous read, one clock of latency.
  logic [7:0] mem [0:1023];
  always @(posedge clk) mem_rdata <= mem[mem_addr[9:0]];

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  int                cyc = 0;
  int                strobes_seen = 0;
  int                last_strobe = 0;
  bit                first_in_run = 1'b1;
  logic [ADDR_W-1:0] addr_ring [8];

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      addr_ring[cyc % 8] = mem_addr;
      if (rst_n && chain_valid_in) begin
        strobes_seen++;
        check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("chain_in", chain_in, e.data);
          check("issue_addr_2clk_before", addr_ring[(cyc + 6) % 8], e.idx);
          if (!first_in_run) check("strobe_gap", cyc - last_strobe, RATE_DIV);
          $display("strobe idx=%0d data=%0d cycle=%0d", e.idx, $signed(chain_in), cyc);
        end
        first_in_run = 1'b0;
        last_strobe  = cyc;
      end
      cyc++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int n, input bit cic);
    exp_t e;
    cfg_num_samples    = ADDR_W'(n);
    cfg_cic_dec_factor = cic;
    for (int i = 0; i < n; i++) begin
      e.idx  = i;
      e.data = mem[i];
      exp_q.push_back(e);
    end
    first_in_run = 1'b1;
    strobes_seen = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    $display("start num=%0d cic=%0d", n, cic);
  endtask

  // Runs until n strobes have been seen; optionally drives random chain
  // status while the run is certainly still streaming.
  task automatic run_traffic(input int n, input bit rnd, inout int vo_cnt,
                             inout logic [FLAG_W-1:0] flg);
    int k = 0;
    while (strobes_seen < n && k < 600) begin
      if (rnd) begin
        chain_valid_out = ($urandom_range(0, 3) == 0);
        chain_flags = ($urandom_range(0, 5) == 0) ?
                      FLAG_W'(1 << $urandom_range(0, FLAG_W - 1)) : '0;
        if (chain_valid_out) vo_cnt++;
        flg |= chain_flags;
      end
      step();
      k++;
    end
    chain_valid_out = 1'b0;
    chain_flags     = '0;
    check("strobes_arrived", strobes_seen, n);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < 3000) begin
      step();
      k++;
    end
    check(name, done, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_valid_in"}, chain_valid_in, 0);
    check({tag, "_chain_in"}, chain_in, 0);
    check({tag, "_out_count"}, out_count, 0);
    check({tag, "_err"}, err_sticky, 0);
    check({tag, "_cic"}, chain_cic_dec_factor, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int               vo;
    logic [FLAG_W-1:0] fl;
    int               n, off;
    bit               cic;

    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Basic stream: samples -4..3
    for (int i = 0; i < 8; i++) mem[i] = 8'(i - 4);
    start_run(8, 1'b1);
    check("busy_after_start", busy, 1);
    vo = 0; fl = '0;
    run_traffic(8, 1'b0, vo, fl);
    wait_done("basic_done");
    check("basic_out_count", out_count, 0);
    check("basic_err", err_sticky, 0);
    check("basic_cic", chain_cic_dec_factor, 1);
    check("basic_queue_empty", exp_q.size(), 0);

    // Zero-length run
    start_run(0, 1'b0);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_out_count", out_count, 0);
    check("zero_cic", chain_cic_dec_factor, 0);
    repeat (6) step();
    check("zero_no_strobes", strobes_seen, 0);

    // Drain timing: output pulses at +10 and +30 after the last input
    for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
    start_run(4, 1'b0);
    run_traffic(4, 1'b0, vo, fl);          // now at last-strobe + 1
    repeat (9) step();
    chain_valid_out = 1'b1;
    step();
    chain_valid_out = 1'b0;
    repeat (19) step();
    chain_valid_out = 1'b1;
    step();
    chain_valid_out = 1'b0;
    repeat (DRAIN_CYCLES - 2) step();
    check("drain_not_yet_done", done, 0);
    check("drain_still_busy", busy, 1);
    step();
    check("drain_done_exact", done, 1);
    check("drain_out_count", out_count, 2);

    // Sticky flags
    for (int i = 0; i < 6; i++) mem[i] = 8'($urandom);
    start_run(6, 1'b1);
    run_traffic(2, 1'b0, vo, fl);
    chain_flags = 10'h004;
    step();
    chain_flags = '0;
    run_traffic(6, 1'b0, vo, fl);
    wait_done("sticky_done");
    check("sticky_err_at_done", err_sticky, 10'h004);
    repeat (5) step();
    check("sticky_err_held", err_sticky, 10'h004);
    start_run(0, 1'b0);
    check("sticky_cleared_by_start", err_sticky, 0);

    // Abort, with an ignored start while busy
    for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
    start_run(8, 1'b1);
    run_traffic(1, 1'b0, vo, fl);
    cfg_num_samples    = ADDR_W'(2);
    cfg_cic_dec_factor = 1'b0;
    start = 1'b1;
    chain_valid_out = 1'b1;
    chain_flags = 10'h201;
    step();
    start = 1'b0;
    chain_valid_out = 1'b0;
    chain_flags = '0;
    check("busy_start_ignored_cic", chain_cic_dec_factor, 1);
    check("busy_start_still_busy", busy, 1);
    run_traffic(3, 1'b0, vo, fl);          // now at third-strobe + 1
    off = $urandom_range(1, 3);
    repeat (off - 1) step();
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    $display("abort offset=%0d", off);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_valid_in", chain_valid_in, 0);
    exp_q.delete();
    repeat (20) step();
    check("abort_no_more_strobes", strobes_seen, 3);
    check("abort_out_count_hold", out_count, 1);
    check("abort_err_hold", err_sticky, 10'h201);
    check("abort_stays_idle", busy, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_in_idle_done", done, 0);
    check("abort_in_idle_count", out_count, 1);

    // Asynchronous reset mid-run
    for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
    start_run(8, 1'b1);
    run_traffic(2, 1'b0, vo, fl);
    chain_valid_out = 1'b1;
    chain_flags = 10'h010;
    step();
    chain_valid_out = 1'b0;
    chain_flags = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 2; i++) mem[i] = 8'($urandom);
    start_run(2, 1'b0);
    run_traffic(2, 1'b0, vo, fl);
    wait_done("post_reset_done");
    check("post_reset_queue_empty", exp_q.size(), 0);
    check("post_reset_out_count", out_count, 0);

    // Randomised runs with random chain status
    for (int r = 0; r < 5; r++) begin
      n   = $urandom_range(1, 24);
      cic = 1'($urandom);
      for (int i = 0; i < n; i++) mem[i] = 8'($urandom);
      start_run(n, cic);
      vo = 0; fl = '0;
      run_traffic(n, 1'b1, vo, fl);
      wait_done("rand_done");
      check("rand_out_count", out_count, vo);
      check("rand_err", err_sticky, fl);
      check("rand_cic", chain_cic_dec_factor, cic);
      check("rand_queue_empty", exp_q.size(), 0);
      $display("run %0d num=%0d out_count=%0d err=%0h", r, n, out_count, err_sticky);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dfe_stream_ctrl.md
Name: dfe_stream_ctrl

Overview:
- Sequencer that streams signed 8-bit stimulus samples from the sample memory into the DFE filter chain (IIR, fractional decimator, CIC).
- Paces input samples at a fixed divided rate and latches the CIC decimation setting for the run.
- Counts chain outputs, accumulates sticky overflow/underflow status, and detects end-of-run by output inactivity.
- Sits between the sample memory and Design_top in the FPGA top level.

Parameters:
- ADDR_W, 19, sample-memory address width; 480000 samples fit.
- RATE_DIV, 4, clocks between consecutive input samples; legal values ≥1.
- DRAIN_CYCLES, 256, idle clocks without chain_valid_out before the run is declared done.
- FLAG_W, 10, number of chain status flags; 5 stages × {overflow, underflow}.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a run. Ignored while busy.
- abort  in  1  one-cycle pulse that terminates a run immediately.
- cfg_num_samples  in  ADDR_W  number of samples to stream. Sampled on start.
- cfg_cic_dec_factor  in  1  CIC decimation select. Sampled on start.
- mem_addr  out  ADDR_W  sample-memory read address. Synchronous read, 1-cycle latency.
- mem_rdata  in  8  signed sample returned by the memory.
- chain_in  out  8  signed sample to chain (top_chain_in).
- chain_valid_in  out  1  sample strobe to chain.
- chain_cic_dec_factor  out  1  latched decimation select.
- chain_valid_out  in  1  chain output strobe.
- chain_flags  in  FLAG_W  chain overflow/underflow flags, OR-reduced per bit.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.
- err_sticky  out  FLAG_W  sticky per-bit flag capture.
- out_count  out  ADDR_W  count of chain_valid_out pulses, saturating.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters 0; rd_pending 0.
- Clock and reset: single clock domain; rst_n is asynchronous, active-low.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start:
  - latch num = cfg_num_samples and chain_cic_dec_factor = cfg_cic_dec_factor;
  - clear rd_ptr, div_cnt, out_count, err_sticky, idle_cnt;
  - go to RUN, or straight to DONE if num == 0.
- RUN:
  - div_cnt counts 0..RATE_DIV-1 and wraps.
  - Issue cycle: when div_cnt == 0 and rd_ptr < num. mem_addr = rd_ptr (registered output). rd_ptr increments; rd_pending is set for the next cycle.
  - Cycle after issue: chain_in <= mem_rdata; chain_valid_in <= 1 for exactly one clock. Total latency is 2 clocks from issue to the strobe.
  - Strobe spacing: exactly RATE_DIV clocks.
  - Exit: when rd_ptr == num and no read is pending or being presented, go to DRAIN.
- DRAIN:
  - idle_cnt increments each clock and resets to 0 on chain_valid_out.
  - When idle_cnt == DRAIN_CYCLES-1, go to DONE.
- DONE: done held high until the next start. chain_cic_dec_factor holds its latched value.
- out_count:
  - increments on chain_valid_out in RUN or DRAIN;
  - saturates at 2^ADDR_W-1;
  - ignored in IDLE and DONE.
- err_sticky: err_sticky |= chain_flags each clock in RUN or DRAIN. Cleared only by start or reset.
- abort (RUN or DRAIN):
  - next state IDLE;
  - chain_valid_in forced 0 that cycle;
  - rd_pending dropped;
  - done stays 0;
  - out_count and err_sticky hold.
- abort in IDLE or DONE: no effect.
- abort and start in the same cycle: abort wins; start is ignored.
- start while busy: ignored; configuration is not re-sampled.
- Reset mid-run: all state returns to reset values asynchronously. No partial strobe is emitted.

Test Plan:
- Basic stream: num=8, RATE_DIV=4, mem[i]=i-4 → 8 chain_valid_in pulses spaced 4 clks, chain_in sequence -4..3. First strobe 2 clks after the first issue (mem_addr=0).
- Zero-length run: start with num=0 → done=1 the next clock, no chain_valid_in, out_count=0.
- Drain timing: after the last input, chain_valid_out pulses at +10 and +30 clks → DONE exactly DRAIN_CYCLES clks after the +30 pulse, out_count=2.
- Sticky flags: chain_flags=10'h004 for 1 clk mid-run → err_sticky=10'h004 through DONE. Next start clears it to 0.
- Abort: abort at sample 3 of 8 → IDLE next clk, no further strobes, done=0, busy=0. start while busy is ignored and cfg values are unchanged.
- Async reset mid-run: rst_n low during RUN → all outputs 0 immediately, state IDLE. Release, then start with num=2 → 2 normal strobes.
